// File: rtl/mux4t1_rr_arbiter.sv
// Round-robin arbiter and select sequencer for a 4:1 WIDTH-bit mux.
// Bounded hold under contention; grant, select and data word are registered together.
module mux4t1_rr_arbiter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  output logic [1:0]       s,
  output logic [3:0]       grant,
  output logic [WIDTH-1:0] o,
  output logic             valid
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned IW   = 2;
  localparam int unsigned CW   = 4;
  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   own;
  logic [IW-1:0]   own_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   ptr_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;

  logic [NREQ-1:0] own_oh;
  logic [NREQ-1:0] others;
  logic [IW-1:0]   pick_all;
  logic [IW-1:0]   pick_oth;
  logic            any_req;
  logic            any_oth;
  logic            new_grant;
  logic [IW-1:0]   new_idx;

  logic [NREQ-1:0]  grant_d;
  logic [IW-1:0]    s_d;
  logic [WIDTH-1:0] o_d;
  logic             valid_d;

  // First set bit of r scanning p, p+1, p+2, p+3 (mod 4); later iterations overwrite,
  // so scanning from the far end leaves the nearest hit.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] idx;
    logic [IW-1:0] res;
    res = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + IW'(k);
      if (r[idx]) res = idx;
    end
    return res;
  endfunction

  always_comb begin
    own_oh      = '0;
    own_oh[own] = 1'b1;
  end

  assign others   = req & ~own_oh;
  assign any_req  = |req;
  assign any_oth  = |others;
  assign pick_all = rr_pick(req, ptr);
  assign pick_oth = rr_pick(others, ptr);

  // State register: FSM state, owner, round-robin pointer, hold counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      own   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      own   <= own_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; every new grant funnels through new_grant/new_idx
  always_comb begin
    state_nxt = state;
    own_nxt   = own;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    new_grant = 1'b0;
    new_idx   = pick_all;

    case (state)
      IDLE: begin
        if (any_req) begin
          new_grant = 1'b1;
          new_idx   = pick_all;
        end
      end
      GRANT: begin
        if (!req[own]) begin
          if (any_req) begin
            new_grant = 1'b1;
            new_idx   = pick_all;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end else if (cnt < HOLD_LIM) begin
          cnt_nxt = cnt + CNT_ONE;
        end else if (any_oth) begin
          new_grant = 1'b1;
          new_idx   = pick_oth;
        end else begin
          cnt_nxt = HOLD_LIM;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    if (new_grant) begin
      state_nxt = GRANT;
      own_nxt   = new_idx;
      ptr_nxt   = new_idx + IW'(1);
      cnt_nxt   = CNT_ONE;
    end
  end

  // Output values derived from the next state so they all move on the same edge
  always_comb begin
    grant_d = '0;
    s_d     = s;
    o_d     = '0;
    valid_d = 1'b0;
    if (state_nxt == GRANT) begin
      grant_d[own_nxt] = 1'b1;
      s_d              = own_nxt;
      valid_d          = 1'b1;
      case (own_nxt)
        2'd0:    o_d = I0;
        2'd1:    o_d = I1;
        2'd2:    o_d = I2;
        default: o_d = I3;
      endcase
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant <= '0;
      s     <= '0;
      o     <= '0;
      valid <= 1'b0;
    end else begin
      grant <= grant_d;
      s     <= s_d;
      o     <= o_d;
      valid <= valid_d;
    end
  end

endmodule
